// File: rtl/scr_frame_ctrl.sv
// scr_frame_ctrl: frame sequencer in front of a serial additive scrambler.
// Each frame is sent as an unscrambled sync word, then the raw header bits,
// then payload bits routed through the external scrambler. Oversize payloads
// are drained without output. Every frame ends with a fixed idle gap.
`timescale 1ns/1ps
module scr_frame_ctrl #(
  parameter int                  SYNC_LEN = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT = 8'hB8,
  parameter int                  HDR_LEN  = 4,
  parameter int                  MAX_PLD  = 64,
  parameter int                  GAP_LEN  = 2,
  parameter int                  SEED_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEED_W-1:0] cfg_seed,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic              in_last,
  output logic              scr_bit,
  output logic              scr_en,
  output logic              scr_load,
  output logic [SEED_W-1:0] scr_seed,
  input  logic              scr_out,
  output logic              out_bit,
  output logic              out_valid,
  output logic              out_sof,
  output logic              busy,
  output logic [7:0]        frame_cnt,
  output logic              hdr_err,
  output logic              len_err
);

  localparam int SC_W = (SYNC_LEN > 1) ? $clog2(SYNC_LEN) : 1;
  localparam int HC_W = (HDR_LEN > 1) ? $clog2(HDR_LEN) : 1;
  localparam int PC_W = $clog2(MAX_PLD + 1);
  localparam int GC_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [SC_W-1:0] SYNC_LAST = SC_W'(SYNC_LEN - 1);
  localparam logic [HC_W-1:0] HDR_LAST  = HC_W'(HDR_LEN - 1);
  localparam logic [PC_W-1:0] PLD_LAST  = PC_W'(MAX_PLD - 1);
  localparam logic [GC_W-1:0] GAP_LAST  = GC_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SYNC,
    S_HDR,
    S_PLD,
    S_DRAIN,
    S_GAP
  } state_t;

  state_t            state_reg;
  logic [SC_W-1:0]   sync_cnt_reg;
  logic [HC_W-1:0]   hdr_cnt_reg;
  logic [PC_W-1:0]   pld_cnt_reg;
  logic [GC_W-1:0]   gap_cnt_reg;
  logic              scr_load_reg;
  logic [SEED_W-1:0] scr_seed_reg;
  logic              out_bit_reg;
  logic              out_valid_reg;
  logic              out_sof_reg;
  logic [7:0]        frame_cnt_reg;
  logic              hdr_err_reg;
  logic              len_err_reg;

  logic in_frame;
  logic accept;
  logic abort_hit;
  logic enter_gap;
  logic sync_bit;

  // States in which upstream bits may be consumed
  assign in_frame  = (state_reg == S_HDR) || (state_reg == S_PLD) || (state_reg == S_DRAIN);
  // Abort blocks acceptance in the same cycle so the bit stays upstream
  assign in_ready  = in_frame && !abort;
  assign accept    = in_valid && in_ready;
  assign abort_hit = abort && (in_frame || (state_reg == S_LOAD) || (state_reg == S_SYNC));
  // Either an abort or an accepted last bit closes the frame
  assign enter_gap = abort_hit || (accept && in_last);

  // The scrambler only advances on accepted payload bits
  assign scr_bit = in_bit;
  assign scr_en  = accept && (state_reg == S_PLD);
  assign busy    = (state_reg != S_IDLE);

  // Sync word goes out MSB first
  assign sync_bit = SYNC_PAT[SYNC_LAST - sync_cnt_reg];

  assign scr_load  = scr_load_reg;
  assign scr_seed  = scr_seed_reg;
  assign out_bit   = out_bit_reg;
  assign out_valid = out_valid_reg;
  assign out_sof   = out_sof_reg;
  assign frame_cnt = frame_cnt_reg;
  assign hdr_err   = hdr_err_reg;
  assign len_err   = len_err_reg;

  // Frame state machine with its counters and registered line/status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      sync_cnt_reg  <= '0;
      hdr_cnt_reg   <= '0;
      pld_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      scr_load_reg  <= 1'b0;
      scr_seed_reg  <= '0;
      out_bit_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      frame_cnt_reg <= 8'd0;
      hdr_err_reg   <= 1'b0;
      len_err_reg   <= 1'b0;
    end else begin
      // Pulses and line-valid default low; each state raises what it needs
      scr_load_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_sof_reg   <= 1'b0;
      hdr_err_reg   <= 1'b0;
      len_err_reg   <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          // Start without consuming: the pending bit is taken later in HDR
          if (in_valid) begin
            state_reg    <= S_LOAD;
            scr_load_reg <= 1'b1;
            scr_seed_reg <= cfg_seed;
          end
        end
        S_LOAD: begin
          pld_cnt_reg  <= '0;
          sync_cnt_reg <= '0;
          state_reg    <= S_SYNC;
        end
        S_SYNC: begin
          if (!abort) begin
            out_valid_reg <= 1'b1;
            out_bit_reg   <= sync_bit;
            out_sof_reg   <= (sync_cnt_reg == '0);
            if (sync_cnt_reg == SYNC_LAST) begin
              hdr_cnt_reg <= '0;
              state_reg   <= S_HDR;
            end else begin
              sync_cnt_reg <= sync_cnt_reg + 1'b1;
            end
          end
        end
        S_HDR: begin
          if (accept) begin
            out_valid_reg <= 1'b1;
            out_bit_reg   <= in_bit;
            if (in_last) begin
              hdr_err_reg <= 1'b1;
            end else if (hdr_cnt_reg == HDR_LAST) begin
              state_reg <= S_PLD;
            end else begin
              hdr_cnt_reg <= hdr_cnt_reg + 1'b1;
            end
          end
        end
        S_PLD: begin
          if (accept) begin
            out_valid_reg <= 1'b1;
            out_bit_reg   <= scr_out;
            pld_cnt_reg   <= pld_cnt_reg + 1'b1;
            // A last bit landing exactly on the limit is a normal end
            if (!in_last && (pld_cnt_reg == PLD_LAST)) begin
              len_err_reg <= 1'b1;
              state_reg   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // Accepted bits are dropped; the exit is handled by enter_gap
        end
        S_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_reg <= S_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase

      // Frame closure overrides the per-state transition
      if (enter_gap) begin
        state_reg     <= S_GAP;
        gap_cnt_reg   <= '0;
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_scr_frame_ctrl.sv
// Bench for scr_frame_ctrl: an environment scrambler model feeds scr_out;
// expected line bits are queued per frame and checked by a separate monitor.
`timescale 1ns/1ps
module tb_scr_frame_ctrl;
  localparam int              HDR_LEN  = 4;
  localparam int              MAX_PLD  = 64;
  localparam int              GAP_LEN  = 2;
  localparam logic [7:0]      SYNC_PAT = 8'hB8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] cfg_seed = 7'd0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready, scr_bit, scr_en, scr_load, scr_out;
  logic [6:0] scr_seed;
  logic       out_bit, out_valid, out_sof, busy, hdr_err, len_err;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  scr_frame_ctrl #(
    .SYNC_LEN(8), .SYNC_PAT(8'hB8), .HDR_LEN(HDR_LEN), .MAX_PLD(MAX_PLD),
    .GAP_LEN(GAP_LEN), .SEED_W(7)
  ) dut (
    .clk(clk), .rst(rst), .cfg_seed(cfg_seed), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_last(in_last),
    .scr_bit(scr_bit), .scr_en(scr_en), .scr_load(scr_load), .scr_seed(scr_seed),
    .scr_out(scr_out), .out_bit(out_bit), .out_valid(out_valid), .out_sof(out_sof),
    .busy(busy), .frame_cnt(frame_cnt), .hdr_err(hdr_err), .len_err(len_err)
  );

  // Environment scrambler: x^7 + x^6 + 1 additive LFSR
  logic [6:0] lfsr;
  always @(posedge clk or negedge rst) begin
    if (!rst)          lfsr <= 7'd0;
    else if (scr_load) lfsr <= scr_seed;
    else if (scr_en)   lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end
  assign scr_out = scr_bit ^ lfsr[6];

  typedef struct packed { logic b; logic sof; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt, load_cnt, hdr_err_cnt, len_err_cnt;
  logic [6:0] last_seed;
  int exp_en, exp_loads, exp_hdr_err, exp_len_err, exp_frames;
  logic [6:0] exp_seed;
  int frame_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every line bit and tallies control pulses
  always @(negedge clk) begin
    if (rst) begin
      if (scr_en)   en_cnt++;
      if (scr_load) begin load_cnt++; last_seed = scr_seed; end
      if (hdr_err)  hdr_err_cnt++;
      if (len_err)  len_err_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("out_with_empty_queue", {31'd0, out_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_bit", {31'd0, out_bit}, {31'd0, mon_e.b});
          check("out_sof", {31'd0, out_sof}, {31'd0, mon_e.sof});
        end
      end else if (out_sof) begin
        check("sof_without_valid", {31'd0, out_sof}, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {23'd0, out_valid, out_bit, out_sof, scr_load, scr_en,
                           in_ready, busy, hdr_err, len_err}, 32'd0);
    check({tag, "_seed"}, {25'd0, scr_seed}, 32'd0);
    check({tag, "_frame_cnt"}, {24'd0, frame_cnt}, 32'd0);
  endtask

  task automatic clear_model();
    exp_q.delete();
    en_cnt = 0; load_cnt = 0; hdr_err_cnt = 0; len_err_cnt = 0; last_seed = 7'd0;
    exp_en = 0; exp_loads = 0; exp_hdr_err = 0; exp_len_err = 0; exp_frames = 0;
    exp_seed = 7'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
    @(posedge clk); #1;
    check_zero("reset");
    clear_model();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b, input logic last);
    bit ok = 0;
    in_valid = 1'b1; in_bit = b; in_last = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    check("handshake", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic bubble();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Frame end: count busy cycles after the closing edge and watch in_ready
  task automatic wait_gap();
    int g = 0; int rdy = 0; bit done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin done = 1; break; end
      g++;
      if (in_ready) rdy++;
    end
    check("gap_reached_idle", {31'd0, done}, 32'd1);
    check("gap_cycles", g, GAP_LEN);
    check("gap_in_ready", rdy, 0);
    check("frame_cnt", {24'd0, frame_cnt}, exp_frames & 255);
    check("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic push_sync(input int nbits);
    exp_t e;
    for (int k = 0; k < nbits; k++) begin
      e.b = SYNC_PAT[7-k]; e.sof = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  // hdr_last_pos: 0 = normal header, n = in_last on header bit n.
  // bubble_mode: 0 none, 1 one idle after each payload bit, 2 random anywhere.
  task automatic run_frame(input logic [6:0] seed, input int hdr_last_pos,
                           input int npld, input int bubble_mode);
    logic hbits[$];
    logic pbits[$];
    logic [6:0] k;
    exp_t e;
    int nh, nout, ntot;
    nh = (hdr_last_pos > 0) ? hdr_last_pos : HDR_LEN;
    for (int i = 0; i < nh; i++) hbits.push_back(1'($urandom_range(0, 1)));
    if (hdr_last_pos == 0)
      for (int i = 0; i < npld; i++) pbits.push_back(1'($urandom_range(0, 1)));
    // Expected line: sync word, raw header, keystream-xored payload up to the limit
    push_sync(8);
    foreach (hbits[i]) begin e.b = hbits[i]; e.sof = 1'b0; exp_q.push_back(e); end
    nout = (hdr_last_pos > 0) ? 0 : ((npld > MAX_PLD) ? MAX_PLD : npld);
    k = seed;
    for (int i = 0; i < nout; i++) begin
      e.b = pbits[i] ^ k[6]; e.sof = 1'b0; exp_q.push_back(e);
      k = lfsr_step(k);
    end
    exp_en += nout;
    exp_len_err += ((hdr_last_pos == 0) && (npld > MAX_PLD)) ? 1 : 0;
    exp_hdr_err += (hdr_last_pos > 0) ? 1 : 0;
    exp_loads++; exp_seed = seed; exp_frames++;
    // Drive
    cfg_seed = seed;
    ntot = nh + pbits.size();
    for (int i = 0; i < ntot; i++) begin
      if (i < nh) send_bit(hbits[i], (hdr_last_pos > 0) && (i == nh - 1));
      else        send_bit(pbits[i-nh], (i == ntot - 1));
      if (i != ntot - 1) begin
        if ((bubble_mode == 1 && i >= nh) ||
            (bubble_mode == 2 && $urandom_range(0, 3) == 0)) bubble();
      end
    end
    wait_gap();
    frame_no++;
    $display("frame %0d: seed=%02h hdr_last=%0d pld=%0d bubbles=%0d frame_cnt=%0d",
             frame_no, seed, hdr_last_pos, (hdr_last_pos > 0) ? 0 : npld, bubble_mode, frame_cnt);
  endtask

  task automatic end_scenario(input string tag);
    check({tag, "_scr_en_count"}, en_cnt, exp_en);
    check({tag, "_load_count"}, load_cnt, exp_loads);
    check({tag, "_load_seed"}, {25'd0, last_seed}, {25'd0, exp_seed});
    check({tag, "_hdr_err_count"}, hdr_err_cnt, exp_hdr_err);
    check({tag, "_len_err_count"}, len_err_cnt, exp_len_err);
  endtask

  initial begin
    clear_model();
    // 1: basic 4 + 10 frame
    do_reset();
    run_frame(7'h5B, 0, 10, 0);
    end_scenario("s1");
    // 2: payload bubbles
    do_reset();
    run_frame(7'h5B, 0, 10, 1);
    end_scenario("s2");
    // 3: oversize payload, then exactly MAX_PLD ending on the limit
    do_reset();
    run_frame(7'h33, 0, 70, 0);
    end_scenario("s3");
    do_reset();
    run_frame(7'h2A, 0, MAX_PLD, 0);
    end_scenario("s3b");
    // 4: in_last on third header bit
    do_reset();
    run_frame(7'h11, 3, 0, 0);
    end_scenario("s4");
    // 5: asynchronous reset while presenting payload bit 5
    do_reset();
    begin
      logic [6:0] k;
      exp_t e;
      logic b;
      cfg_seed = 7'h4C;
      push_sync(8);
      k = 7'h4C;
      for (int i = 0; i < HDR_LEN; i++) begin
        b = 1'($urandom_range(0, 1));
        e.b = b; e.sof = 1'b0; exp_q.push_back(e);
        send_bit(b, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
        b = 1'($urandom_range(0, 1));
        e.b = b ^ k[6]; e.sof = 1'b0; exp_q.push_back(e);
        k = lfsr_step(k);
        send_bit(b, 1'b0);
      end
      in_valid = 1'b1; in_bit = 1'b1;
      @(negedge clk); #2;
      check("s5_outputs_before_reset", exp_q.size(), 0);
      rst = 1'b0; in_valid = 1'b0;
      #1;
      check_zero("s5_async");
      @(posedge clk); #1;
      clear_model();
      rst = 1'b1;
      @(posedge clk); #1;
      run_frame(7'h66, 0, 3, 0);
      end_scenario("s5");
    end
    // 6: two frames, second aborted during sync
    do_reset();
    run_frame(7'h01, 0, 6, 0);
    begin
      bit seen = 0;
      cfg_seed = 7'h7F;
      push_sync(2);
      exp_loads++; exp_seed = 7'h7F; exp_frames++;
      in_valid = 1'b1; in_bit = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (scr_load) begin seen = 1; break; end
      end
      check("s6_load_seen", {31'd0, seen}, 32'd1);
      @(posedge clk); @(posedge clk); @(posedge clk); #1;
      abort = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      abort = 1'b0;
      wait_gap();
      end_scenario("s6");
    end
    // 7: random frames with random bubbles
    do_reset();
    for (int f = 0; f < 8; f++) begin
      logic [6:0] sd;
      int hl;
      sd = 7'($urandom_range(1, 127));
      hl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, HDR_LEN)) : 0;
      run_frame(sd, hl, int'($urandom_range(1, 70)), 2);
    end
    end_scenario("s7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scr_frame_ctrl.md
Name: scr_frame_ctrl

Overview:
- Frame sequencer for the serial additive scrambler (1-bit bit_in/bit_out datapath, LFSR advancing on clk when enabled).
- Takes a bit-serial frame stream from upstream, emits an unscrambled sync word, then passes the header unscrambled and the payload through the scrambler.
- Drives the scrambler's seed load, enable and data input, and selects raw or scrambled bits onto the line output.
- Sits between the framer and the line serializer.

Parameters:
SYNC_LEN, 8, sync word length in bits
SYNC_PAT, 8'hB8, sync word, SYNC_LEN bits wide, sent MSB first
HDR_LEN, 4, unscrambled header bits at frame start
MAX_PLD, 64, maximum payload bits per frame
GAP_LEN, 2, idle cycles between frames
SEED_W, 7, scrambler seed width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
cfg_seed  in  SEED_W  seed, latched at frame start
abort  in  1  synchronous frame abort
in_valid  in  1  upstream bit valid
in_ready  out  1  upstream bit accepted when in_valid&&in_ready
in_bit  in  1  upstream data bit
in_last  in  1  marks last bit of frame
scr_bit  out  1  scrambler data input; equals in_bit (combinational)
scr_en  out  1  scrambler advance enable (combinational)
scr_load  out  1  one-cycle seed load pulse (registered)
scr_seed  out  SEED_W  seed value presented with scr_load
scr_out  in  1  scrambler output, combinational from scr_bit in same cycle
out_bit  out  1  line bit (registered)
out_valid  out  1  line bit valid (registered)
out_sof  out  1  high with first sync bit
busy  out  1  state != IDLE
frame_cnt  out  8  completed/aborted frame count, wraps 255->0
hdr_err  out  1  one-cycle pulse: in_last during header
len_err  out  1  one-cycle pulse: payload exceeded MAX_PLD

Behaviour:
- Reset (async, rst=0):
  - State=IDLE.
  - All outputs 0, including scr_seed, frame_cnt, counters, and in_ready.
- States: IDLE, LOAD, SYNC, HDR, PLD, DRAIN, GAP.
- IDLE:
  - in_ready=0.
  - in_valid=1 -> LOAD; no bit is consumed.
- LOAD (1 cycle):
  - scr_load=1.
  - scr_seed=cfg_seed sampled on the IDLE->LOAD edge, held until next LOAD.
  - -> SYNC.
- SYNC (SYNC_LEN cycles):
  - in_ready=0.
  - Next cycle: out_valid=1, out_bit=SYNC_PAT[SYNC_LEN-1-k].
  - out_sof=1 with k=0.
  - -> HDR.
- HDR:
  - in_ready=1.
  - Each accepted bit appears on out_bit one cycle later, out_valid=1, raw (unscrambled); scr_en=0.
  - After HDR_LEN accepted bits -> PLD.
  - in_last on an accepted header bit: the bit is output, hdr_err pulses, -> GAP.
- PLD:
  - in_ready=1.
  - scr_en = in_valid (acceptance); out_bit registers scr_out.
  - in_last accepted -> GAP.
  - The MAX_PLD-th accepted bit without in_last -> DRAIN with len_err pulse.
- DRAIN:
  - in_ready=1, scr_en=0, out_valid=0.
  - Bits are discarded until in_last is accepted -> GAP.
- Bubbles (in_valid=0 in HDR/PLD):
  - Next-cycle out_valid=0.
  - Scrambler does not advance; counters hold.
- GAP (GAP_LEN cycles):
  - in_ready=0, out_valid=0.
  - frame_cnt increments on GAP entry.
  - -> IDLE.
- abort=1 in LOAD/SYNC/HDR/PLD/DRAIN:
  - -> GAP next cycle; the current-cycle bit is not accepted (in_ready forced 0).
  - abort is ignored in IDLE and GAP.
- Simultaneous events:
  - in_last and MAX_PLD on the same bit -> normal end, no len_err.
  - abort wins over in_last.
- Counters:
  - Payload counter is width clog2(MAX_PLD+1), cleared in LOAD.
  - Header and sync counters are cleared on state entry.
- Reset mid-frame: immediate return to IDLE, no error pulse, frame_cnt=0.

Test Plan:
1. cfg_seed=7'h5B; in_valid held 1; 14 bits, in_last on bit 14 -> checks:
   - scr_load one cycle with scr_seed=7'h5B.
   - out_bit 1,0,1,1,1,0,0,0 with out_sof on the first bit.
   - Next 4 outputs equal the header inputs.
   - 10 outputs equal scr_out, with scr_en high for exactly 10 accepted bits.
   - in_ready=0 for 2 GAP cycles; frame_cnt=1.
2. Same frame with in_valid toggling 1,0 during PLD -> checks:
   - out_valid has bubbles matching the input gaps.
   - scr_en count still 10; output order preserved.
3. Header plus 70 payload bits, in_last on 70th -> checks:
   - scr_en asserted 64 times; len_err pulses once after the 64th bit.
   - 6 bits consumed with out_valid=0; then GAP; frame_cnt=1.
4. in_last on 3rd header bit -> checks:
   - 3 header bits output; hdr_err=1 for one cycle.
   - scr_en never asserted; GAP follows.
5. rst=0 for 1 cycle mid-PLD (bit 5) -> checks:
   - All outputs 0 immediately; busy=0.
   - The next in_valid starts a fresh frame with a new scr_load.
6. Two back-to-back frames with cfg_seed 7'h01 then 7'h7F, with abort asserted during SYNC of frame 2 -> checks:
   - Second scr_load shows 7'h7F.
   - Frame 2 emits no header bits; frame_cnt=2.
